// File: rtl/regfile_wport_arb_pkg.sv
// Shared widths, register-zero constant, queue entry layout and starvation FSM states
// for the regfile write-port arbiter.
package regfile_wport_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } starve_st_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     wdata;
  } wr_t;

endpackage

// File: rtl/regfile_wq_fifo.sv
// Circular write queue with per-entry live bit, squash-by-address and two CAM lookups.
// Head visible the cycle after push; push must only be asserted while !full.
module regfile_wq_fifo
  import regfile_wport_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wr_t                   push_dat,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [REG_ADDR_W-1:0] squash_reg,
  input  logic [REG_ADDR_W-1:0] rreg1,
  input  logic [REG_ADDR_W-1:0] rreg2,
  output wr_t                   head_dat,
  output logic                  head_vld,
  output logic                  head_live,
  output logic                  full,
  output logic                  any_live,
  output logic                  pend1,
  output logic                  pend2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wr_t              mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].wreg == squash_reg) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rptr] <= 1'b0;
        rptr       <= rptr + PW'(1);
      end
      // an entry arriving alongside a same-register pipeline write is already stale
      if (push) begin
        live[wptr] <= !(squash && push_dat.wreg == squash_reg);
        wptr       <= wptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat  = mem[rptr];
  assign head_vld  = (count != '0);
  assign head_live = live[rptr];
  assign full      = (count == CW'(DEPTH));
  assign any_live  = |live;

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && mem[i].wreg == rreg1) pend1 = 1'b1;
      if (live[i] && mem[i].wreg == rreg2) pend2 = 1'b1;
    end
    if (rreg1 == REG_ZERO) pend1 = 1'b0;
    if (rreg2 == REG_ZERO) pend2 = 1'b0;
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// Arbitrates the regfile write port: pipeline writeback wins, queued multi-cycle results fill gaps
// (>=1 cycle latency, 0 with REGFILE_WPORT_BYPASS_EN); mc_ready drops when the queue is full.
module regfile_wport_arb
  import regfile_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wreg,
  input  logic [DATA_W-1:0]     wb_wdata,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_wreg,
  input  logic [DATA_W-1:0]     mc_wdata,
  input  logic [REG_ADDR_W-1:0] rreg1,
  input  logic [REG_ADDR_W-1:0] rreg2,
  output logic                  pend1,
  output logic                  pend2,
  output logic                  stall_req,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] wreg,
  output logic [DATA_W-1:0]     wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic       a_wr, byp, q_push, q_pop, q_full;
  logic       head_vld, head_live, any_live, head_write, blocked;
  wr_t        head_dat, q_dat;
  starve_st_t st, st_n;
  logic [SW-1:0] cnt, cnt_n;

  assign a_wr     = wb_regwrite && (wb_wreg != REG_ZERO);
  assign mc_ready = !q_full;
  assign q_dat    = '{wreg: mc_wreg, wdata: mc_wdata};

`ifdef REGFILE_WPORT_BYPASS_EN
  assign byp = mc_valid && (mc_wreg != REG_ZERO) && !a_wr && !head_vld;
`else
  assign byp = 1'b0;
`endif

  assign q_push     = mc_valid && mc_ready && (mc_wreg != REG_ZERO) && !byp;
  assign head_write = head_vld && head_live && !a_wr;
  assign blocked    = head_vld && head_live && a_wr;
  // dead heads retire silently whether or not the pipeline holds the port
  assign q_pop      = head_vld && (!head_live || !a_wr);

  regfile_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_dat   (q_dat),
    .pop        (q_pop),
    .squash     (a_wr),
    .squash_reg (wb_wreg),
    .rreg1      (rreg1),
    .rreg2      (rreg2),
    .head_dat   (head_dat),
    .head_vld   (head_vld),
    .head_live  (head_live),
    .full       (q_full),
    .any_live   (any_live),
    .pend1      (pend1),
    .pend2      (pend2)
  );

  always_comb begin
    regwrite = 1'b0;
    wreg     = REG_ZERO;
    wdata    = '0;
    if (a_wr) begin
      regwrite = 1'b1;
      wreg     = wb_wreg;
      wdata    = wb_wdata;
    end else if (head_vld && head_live) begin
      regwrite = 1'b1;
      wreg     = head_dat.wreg;
      wdata    = head_dat.wdata;
    end else if (byp) begin
      regwrite = 1'b1;
      wreg     = mc_wreg;
      wdata    = mc_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (any_live) st_n = WAIT;
      end
      WAIT: begin
        if (!any_live) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else if (head_write) begin
          cnt_n = '0;
        end else if (cnt == SW'(STARVE_MAX)) begin
          st_n = FORCE;
        end else if (blocked) begin
          cnt_n = cnt + SW'(1);
        end
      end
      FORCE: begin
        if (!any_live) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else if (head_write) begin
          st_n  = WAIT;
          cnt_n = '0;
        end
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  assign stall_req = (st == FORCE);

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb with a queue-level reference model checked every negedge.
module tb_regfile_wport_arb;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_regwrite;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wreg;
  logic [31:0] mc_wdata;
  logic [4:0]  rreg1, rreg2;
  logic        pend1, pend2, stall_req, regwrite;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  // reference model: queued writes as parallel queues, plus starvation bookkeeping
  logic [4:0]  qr [$];
  logic [31:0] qd [$];
  bit          ql [$];
  bit          m_watch, m_force;
  int          m_cnt;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_regwrite (wb_regwrite),
    .wb_wreg     (wb_wreg),
    .wb_wdata    (wb_wdata),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_wreg     (mc_wreg),
    .mc_wdata    (mc_wdata),
    .rreg1       (rreg1),
    .rreg2       (rreg2),
    .pend1       (pend1),
    .pend2       (pend2),
    .stall_req   (stall_req),
    .regwrite    (regwrite),
    .wreg        (wreg),
    .wdata       (wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (!reset && regwrite) rf[wreg] <= wdata;
  end

  always @(negedge clk) begin : cmp
    bit          ar, byp, hl, rdy, p1, p2, hw, bl;
    logic [31:0] e_rw, e_wr, e_wd;
    int          nlive;
    if (reset) begin
      qr.delete(); qd.delete(); ql.delete();
      m_watch = 0; m_force = 0; m_cnt = 0;
      chk("m_rst_regwrite", 32'(regwrite), 0);
      chk("m_rst_stall", 32'(stall_req), 0);
      chk("m_rst_ready", 32'(mc_ready), 1);
      chk("m_rst_pend", {30'd0, pend2, pend1}, 0);
      chk("m_rst_wreg", 32'(wreg), 0);
      chk("m_rst_wdata", wdata, 0);
    end else begin
      ar  = wb_regwrite && (wb_wreg != 5'd0);
      hl  = (qr.size() > 0) && ql[0];
      rdy = (qr.size() < DEPTH);
      byp = 0;
`ifdef REGFILE_WPORT_BYPASS_EN
      byp = (qr.size() == 0) && !ar && mc_valid && (mc_wreg != 5'd0);
`endif
      e_rw = 0; e_wr = 0; e_wd = 0;
      if (ar) begin
        e_rw = 1; e_wr = 32'(wb_wreg); e_wd = wb_wdata;
      end else if (hl) begin
        e_rw = 1; e_wr = 32'(qr[0]); e_wd = qd[0];
      end else if (byp) begin
        e_rw = 1; e_wr = 32'(mc_wreg); e_wd = mc_wdata;
      end
      nlive = 0; p1 = 0; p2 = 0;
      foreach (ql[i]) begin
        if (ql[i]) begin
          nlive++;
          if (qr[i] == rreg1 && rreg1 != 5'd0) p1 = 1;
          if (qr[i] == rreg2 && rreg2 != 5'd0) p2 = 1;
        end
      end
      chk("m_regwrite", 32'(regwrite), e_rw);
      if (e_rw == 1) begin
        chk("m_wreg", 32'(wreg), e_wr);
        chk("m_wdata", wdata, e_wd);
      end
      chk("m_ready", 32'(mc_ready), 32'(rdy));
      chk("m_pend1", 32'(pend1), 32'(p1));
      chk("m_pend2", 32'(pend2), 32'(p2));
      chk("m_stall", 32'(stall_req), 32'(m_force));

      hw = !ar && hl;
      bl = ar && hl;
      if (nlive == 0) begin
        m_watch = 0; m_force = 0; m_cnt = 0;
      end else if (!m_watch) begin
        m_watch = 1;
      end else if (hw) begin
        m_force = 0; m_cnt = 0;
      end else if (!m_force && m_cnt == STARVE_MAX) begin
        m_force = 1;
      end else if (!m_force && bl) begin
        m_cnt++;
      end

      if (qr.size() > 0 && (!ql[0] || !ar)) begin
        qr.delete(0); qd.delete(0); ql.delete(0);
      end
      if (ar) begin
        foreach (qr[i]) if (qr[i] == wb_wreg) ql[i] = 1'b0;
      end
      if (mc_valid && rdy && mc_wreg != 5'd0 && !byp) begin
        qr.push_back(mc_wreg);
        qd.push_back(mc_wdata);
        ql.push_back(!(ar && mc_wreg == wb_wreg));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    wb_regwrite = 0; wb_wreg = 0; wb_wdata = 0;
    mc_valid = 0; mc_wreg = 0; mc_wdata = 0;
    rreg1 = 0; rreg2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 32'(regwrite), 0);
    chk("rst_ready", 32'(mc_ready), 1);
    chk("rst_stall", 32'(stall_req), 0);
    reset = 1'b0;

    // pipeline-only write passes through in the same cycle
    step();
    wb_regwrite = 1; wb_wreg = 5'd1; wb_wdata = 32'd14;
    #1;
    chk("a_regwrite", 32'(regwrite), 1);
    chk("a_wreg", 32'(wreg), 1);
    chk("a_wdata", wdata, 14);
    chk("a_ready", 32'(mc_ready), 1);
    step();
    wb_regwrite = 0;

    // single multi-cycle result
    mc_valid = 1; mc_wreg = 5'd3; mc_wdata = 32'hDEAD; rreg1 = 5'd3;
    #1;
`ifdef REGFILE_WPORT_BYPASS_EN
    chk("b_byp_wreg", 32'(wreg), 3);
`else
    chk("b_same_cycle_idle", 32'(regwrite), 0);
`endif
    step();
    mc_valid = 0;
    #1;
`ifndef REGFILE_WPORT_BYPASS_EN
    chk("b_regwrite", 32'(regwrite), 1);
    chk("b_wreg", 32'(wreg), 3);
    chk("b_wdata", wdata, 32'hDEAD);
    chk("b_pend1", 32'(pend1), 1);
`endif
    step();
    #1;
    chk("b_drained", 32'(regwrite), 0);
    rreg1 = 0;

    // fill the queue while the pipeline owns the port
    wb_regwrite = 1; wb_wreg = 5'd2; wb_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_wreg = 5'(5 + i); mc_wdata = 32'(100 + i);
      #1;
      chk("fill_ready", 32'(mc_ready), 1);
      step();
    end
    mc_valid = 0; rreg2 = 5'd6;
    #1;
    chk("full_ready", 32'(mc_ready), 0);
    chk("full_pend2", 32'(pend2), 1);
    chk("full_port_a", 32'(wreg), 2);
    step(); step();
    chk("starve_not_yet", 32'(stall_req), 0);
    step();
    chk("starve_stall", 32'(stall_req), 1);
    wb_regwrite = 0; rreg2 = 0;
    #1;
    chk("drain5_wreg", 32'(wreg), 5);
    chk("drain5_wdata", wdata, 100);
    chk("drain5_stall", 32'(stall_req), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_wreg", 32'(wreg), 32'(5 + i));
      chk("drain_stall", 32'(stall_req), 0);
    end
    step();
    chk("drain_empty", 32'(regwrite), 0);
    chk("drain_ready", 32'(mc_ready), 1);

    // WAW squash of a queued write by a younger pipeline write
    wb_regwrite = 1; wb_wreg = 5'd2; wb_wdata = 32'h22;
    mc_valid = 1; mc_wreg = 5'd9; mc_wdata = 32'd1; rreg1 = 5'd9;
    step();
    mc_valid = 0; wb_wreg = 5'd9; wb_wdata = 32'd2;
    #1;
    chk("sq_a_wreg", 32'(wreg), 9);
    chk("sq_a_wdata", wdata, 2);
    chk("sq_pend_before", 32'(pend1), 1);
    step();
    wb_regwrite = 0;
    #1;
    chk("sq_dead_pop", 32'(regwrite), 0);
    chk("sq_pend_after", 32'(pend1), 0);
    step(); step();
    chk("sq_rf9", rf[9], 2);
    rreg1 = 0;

    // reset while entries are queued and the stall is raised
    wb_regwrite = 1; wb_wreg = 5'd2; rreg1 = 5'd10;
    for (int i = 0; i < 2; i++) begin
      mc_valid = 1; mc_wreg = 5'(10 + i); mc_wdata = 32'(32'hA + i);
      step();
    end
    mc_valid = 0;
    n = 0;
    while (!stall_req && n < 20) begin
      step();
      n++;
    end
    chk("rst_mid_stall_cycles", 32'(n), 5);
    chk("rst_mid_pend_before", 32'(pend1), 1);
    #2;
    reset = 1; wb_regwrite = 0;
    #1;
    chk("rst_mid_regwrite", 32'(regwrite), 0);
    chk("rst_mid_stall", 32'(stall_req), 0);
    chk("rst_mid_ready", 32'(mc_ready), 1);
    chk("rst_mid_pend", 32'(pend1), 0);
    chk("rst_mid_wreg", 32'(wreg), 0);
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_write", 32'(regwrite), 0);
    end
    rreg1 = 0;

    // register zero from both sides
    wb_regwrite = 1; wb_wreg = 5'd0; wb_wdata = 32'h55;
    mc_valid = 1; mc_wreg = 5'd0; mc_wdata = 32'h66;
    #1;
    chk("r0_regwrite", 32'(regwrite), 0);
    chk("r0_ready", 32'(mc_ready), 1);
    step();
    mc_valid = 0; wb_regwrite = 0;
    #1;
    chk("r0_not_queued", 32'(regwrite), 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
